// File: rtl/friscv_memfy_responder.sv
// AXI4-lite register-array memory answering the memfy initiator.
// One-entry AW and W buffers feed a write commit; reads return one cycle after the AR handshake.
module friscv_memfy_responder #(
  parameter int XLEN       = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_ID_W   = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  aclk,
  input  logic                  srst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [AXI_ADDR_W-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic [3:0]            awcache,
  input  logic [AXI_ID_W-1:0]   awid,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [XLEN-1:0]       wdata,
  input  logic [XLEN/8-1:0]     wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [AXI_ID_W-1:0]   bid,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [AXI_ADDR_W-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic [3:0]            arcache,
  input  logic [AXI_ID_W-1:0]   arid,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [AXI_ID_W-1:0]   rid,
  output logic [1:0]            rresp,
  output logic [XLEN-1:0]       rdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = XLEN / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic out_of_range(input logic [AXI_ADDR_W-1:0] addr);
    return (addr >> (IDX_W + 2)) != '0;
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [AXI_ADDR_W-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  logic [XLEN-1:0]       mem [DEPTH];

  logic                  aw_full;
  logic [AXI_ADDR_W-1:0] aw_addr_buf;
  logic [AXI_ID_W-1:0]   aw_id_buf;
  logic                  w_full;
  logic [XLEN-1:0]       w_data_buf;
  logic [NB-1:0]         w_strb_buf;

  logic commit;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic aw_oor;
  logic ar_oor;

  // Protection and cache attributes carry no meaning for this memory.
  logic unused_attr;
  assign unused_attr = ^{awprot, awcache, arprot, arcache};

  assign commit  = aw_full & w_full & (~bvalid | bready);
  assign awready = ~aw_full | commit;
  assign wready  = ~w_full | commit;
  assign arready = ~rvalid | rready;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign ar_hs   = arvalid & arready;
  assign aw_oor  = out_of_range(aw_addr_buf);
  assign ar_oor  = out_of_range(araddr);

  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      aw_addr_buf <= awaddr;
      aw_id_buf   <= awid;
    end
    if (w_hs) begin
      w_data_buf <= wdata;
      w_strb_buf <= wstrb;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rresp   <= '0;
      rdata   <= '0;
    end else begin
      if (aw_hs)
        aw_full <= 1'b1;
      else if (commit)
        aw_full <= 1'b0;

      if (w_hs)
        w_full <= 1'b1;
      else if (commit)
        w_full <= 1'b0;

      if (commit) begin
        bvalid <= 1'b1;
        bid    <= aw_id_buf;
        bresp  <= aw_oor ? RESP_DECERR : RESP_OKAY;
      end else if (bready) begin
        bvalid <= 1'b0;
      end

      // The array read sees pre-commit contents, so a same-word write lands after the read.
      if (ar_hs) begin
        rvalid <= 1'b1;
        rid    <= arid;
        rresp  <= ar_oor ? RESP_DECERR : RESP_OKAY;
        rdata  <= ar_oor ? '0 : mem[word_index(araddr)];
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // Memory contents survive reset; a commit in the reset cycle is discarded.
  always_ff @(posedge aclk) begin
    if (commit && !srst && !aw_oor) begin
      for (int b = 0; b < NB; b++) begin
        if (w_strb_buf[b])
          mem[word_index(aw_addr_buf)][b*8 +: 8] <= w_data_buf[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_friscv_memfy_responder.sv
// Directed bench for friscv_memfy_responder: a scoreboard queues expected B/R
// responses as stimulus is driven and a negedge monitor pops them on each handshake.
module tb_friscv_memfy_responder;

  localparam int XLEN  = 32;
  localparam int AW    = 32;
  localparam int IDW   = 8;
  localparam int DEPTH = 256;

  logic            aclk;
  logic            srst;
  logic            awvalid;
  logic            awready;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic [3:0]      awcache;
  logic [IDW-1:0]  awid;
  logic            wvalid;
  logic            wready;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wstrb;
  logic            bvalid;
  logic            bready;
  logic [IDW-1:0]  bid;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic [3:0]      arcache;
  logic [IDW-1:0]  arid;
  logic            rvalid;
  logic            rready;
  logic [IDW-1:0]  rid;
  logic [1:0]      rresp;
  logic [XLEN-1:0] rdata;

  friscv_memfy_responder #(
    .XLEN(XLEN), .AXI_ADDR_W(AW), .AXI_ID_W(IDW), .DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .srst(srst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .awcache(awcache), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .arcache(arcache), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rresp(rresp), .rdata(rdata)
  );

  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_t;
  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; logic [XLEN-1:0] data; } r_t;

  b_t bq[$];
  r_t rq[$];
  logic [XLEN-1:0] model [DEPTH];
  int total = 0;
  int bad = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge aclk) begin
    b_t eb;
    r_t er;
    if (!srst && bvalid && bready) begin
      if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
      else begin
        eb = bq.pop_front();
        check("sb_bid", 64'(bid), 64'(eb.id));
        check("sb_bresp", 64'(bresp), 64'(eb.resp));
      end
    end
    if (!srst && rvalid && rready) begin
      if (rq.size() == 0) check("r_unexpected", 64'd1, 64'd0);
      else begin
        er = rq.pop_front();
        check("sb_rid", 64'(rid), 64'(er.id));
        check("sb_rresp", 64'(rresp), 64'(er.resp));
        check("sb_rdata", 64'(rdata), 64'(er.data));
      end
    end
  end

  function automatic logic oor(input logic [AW-1:0] a);
    return a >= AW'(DEPTH * 4);
  endfunction

  task automatic send_aw(input logic [AW-1:0] a, input logic [IDW-1:0] id);
    int n = 0;
    awaddr = a; awid = id; awvalid = 1'b1;
    @(negedge aclk);
    while (!awready && n < 50) begin n++; @(negedge aclk); end
    if (!awready) check("aw_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [XLEN-1:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge aclk);
    while (!wready && n < 50) begin n++; @(negedge aclk); end
    if (!wready) check("w_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input logic [IDW-1:0] id);
    int n = 0;
    araddr = a; arid = id; arvalid = 1'b1;
    @(negedge aclk);
    while (!arready && n < 50) begin n++; @(negedge aclk); end
    if (!arready) check("ar_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                              input logic [3:0] s, input logic [IDW-1:0] id);
    b_t e;
    e.id = id;
    e.resp = oor(a) ? 2'b11 : 2'b00;
    bq.push_back(e);
    if (!oor(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                       input logic [3:0] s, input logic [IDW-1:0] id);
    expect_write(a, d, s, id);
    fork
      send_aw(a, id);
      send_w(d, s);
    join
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [IDW-1:0] id);
    r_t e;
    e.id = id;
    e.resp = oor(a) ? 2'b11 : 2'b00;
    e.data = oor(a) ? '0 : model[a[9:2]];
    rq.push_back(e);
    send_ar(a, id);
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin
      @(negedge aclk); n++;
    end
    if (n >= 100) check("drain_timeout", 64'd0, 64'd1);
    @(posedge aclk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XLEN-1:0] old;
    r_t er;
    logic [AW-1:0] addrs [4];
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h20; addrs[3] = 32'h24;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    awvalid = 0; awaddr = 0; awprot = 0; awcache = 0; awid = 0;
    wvalid = 0; wdata = 0; wstrb = 0;
    arvalid = 0; araddr = 0; arprot = 0; arcache = 0; arid = 0;
    bready = 1; rready = 1; srst = 1;

    // Reset state
    @(posedge aclk); #1;
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_wready", 64'(wready), 64'd1);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    srst = 0;
    @(posedge aclk); #1;

    // Basic write then read
    write(32'h10, 32'hDEADBEEF, 4'hF, 8'h05);
    check("b_not_early", 64'(bvalid), 64'd0);
    @(posedge aclk); #1;
    check("b_latency", 64'(bvalid), 64'd1);
    check("b_id", 64'(bid), 64'h05);
    check("b_resp", 64'(bresp), 64'd0);
    read(32'h10, 8'h07);
    check("r_latency", 64'(rvalid), 64'd1);
    check("r_data", 64'(rdata), 64'hDEADBEEF);
    drain();

    // Partial strobe and zero strobe
    write(32'h10, 32'h11112222, 4'h3, 8'h01);
    drain();
    read(32'h10, 8'h02);
    check("strb_lo", 64'(rdata), 64'hDEAD2222);
    drain();
    write(32'h10, 32'hFFFFFFFF, 4'h0, 8'h03);
    drain();
    read(32'h10, 8'h04);
    check("strb_zero", 64'(rdata), 64'hDEAD2222);
    drain();

    // W ahead of AW
    expect_write(32'h14, 32'hCAFEF00D, 4'hF, 8'h09);
    send_w(32'hCAFEF00D, 4'hF);
    check("w_first_wready", 64'(wready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      check("w_first_no_b", 64'(bvalid), 64'd0);
    end
    send_aw(32'h14, 8'h09);
    check("w_first_commit_cycle", 64'(bvalid), 64'd0);
    @(posedge aclk); #1;
    check("w_first_b", 64'(bvalid), 64'd1);
    check("w_first_bid", 64'(bid), 64'h09);
    drain();
    read(32'h14, 8'h0A);
    drain();

    // B backpressure with two writes in flight
    bready = 0;
    write(32'h20, 32'h00000001, 4'hF, 8'h21);
    write(32'h24, 32'h00000002, 4'hF, 8'h22);
    check("bp_awready", 64'(awready), 64'd0);
    check("bp_wready", 64'(wready), 64'd0);
    check("bp_bvalid", 64'(bvalid), 64'd1);
    check("bp_bid_first", 64'(bid), 64'h21);
    bready = 1;
    @(posedge aclk); #1;
    check("bp_second_valid", 64'(bvalid), 64'd1);
    check("bp_bid_second", 64'(bid), 64'h22);
    drain();
    read(32'h20, 8'h23);
    read(32'h24, 8'h24);
    drain();

    // Same-word read and commit in one cycle returns old data
    old = model[8];
    write(32'h20, 32'h55AA55AA, 4'hF, 8'h30);
    er.id = 8'h31; er.resp = 2'b00; er.data = old;
    rq.push_back(er);
    send_ar(32'h20, 8'h31);
    check("rbw_old", 64'(rdata), 64'(old));
    drain();
    read(32'h20, 8'h32);
    check("rbw_new", 64'(rdata), 64'h55AA55AA);
    drain();

    // Back-to-back reads, one per cycle
    arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      araddr = addrs[i]; arid = 8'(8'h40 + i);
      er.id = arid; er.resp = 2'b00; er.data = model[addrs[i][9:2]];
      rq.push_back(er);
      @(negedge aclk);
      check("b2b_arready", 64'(arready), 64'd1);
      @(posedge aclk); #1;
      check("b2b_rvalid", 64'(rvalid), 64'd1);
    end
    arvalid = 1'b0;
    drain();

    // R backpressure keeps response stable
    rready = 0;
    read(32'h14, 8'h48);
    check("rbp_arready", 64'(arready), 64'd0);
    repeat (2) begin
      @(posedge aclk); #1;
      check("rbp_rvalid", 64'(rvalid), 64'd1);
      check("rbp_rid", 64'(rid), 64'h48);
      check("rbp_rdata", 64'(rdata), 64'hCAFEF00D);
    end
    rready = 1;
    drain();

    // Out-of-range access
    write(32'h0, 32'hA5A50000, 4'hF, 8'h50);
    drain();
    write(32'h400, 32'h12345678, 4'hF, 8'h51);
    drain();
    read(32'h400, 8'h52);
    check("oor_rresp", 64'(rresp), 64'h3);
    check("oor_rdata", 64'(rdata), 64'd0);
    drain();
    read(32'h0, 8'h53);
    check("oor_word0", 64'(rdata), 64'hA5A50000);
    drain();

    // Reset mid-transaction drops pending response and buffered W
    bready = 0;
    write(32'h28, 32'h00000077, 4'hF, 8'h60);
    @(posedge aclk); #1;
    send_w(32'h00000088, 4'hF);
    srst = 1;
    @(posedge aclk); #1;
    srst = 0;
    bq.delete();
    check("mid_rst_bvalid", 64'(bvalid), 64'd0);
    check("mid_rst_wready", 64'(wready), 64'd1);
    check("mid_rst_awready", 64'(awready), 64'd1);
    bready = 1;
    expect_write(32'h2C, 32'h00000066, 4'hF, 8'h61);
    send_aw(32'h2C, 8'h61);
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk); #1;
      check("mid_rst_w_dropped", 64'(bvalid), 64'd0);
    end
    send_w(32'h00000066, 4'hF);
    drain();
    read(32'h28, 8'h62);
    read(32'h2C, 8'h63);
    drain();

    check("bq_empty", 64'(bq.size()), 64'd0);
    check("rq_empty", 64'(rq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
